// File: rtl/key_input_conditioner_pkg.sv
// Shared definitions for the key input conditioner: repeat FSM states and
// default timing constants matching the game-logic clock.
package key_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCKED = 2'd3
  } repeat_state_t;

  localparam int DEF_CLOCK_FREQUENCY      = 40;
  localparam int DEF_DEBOUNCE_CYCLES      = 2;
  localparam int DEF_REPEAT_DELAY_CYCLES  = DEF_CLOCK_FREQUENCY / 4;
  localparam int DEF_REPEAT_PERIOD_CYCLES = DEF_CLOCK_FREQUENCY / 10;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_input_conditioner_key_channel.sv
// One button path: two-flop synchroniser, debounce counter and a rising-edge
// detect on the debounced level.
module key_channel #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_deb,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic          r_debPrev;
  logic [CW-1:0] r_cnt;

  // The counter only ever runs while the synchronised level disagrees with deb,
  // so any glitch shorter than DEBOUNCE_CYCLES clears it before it can flip deb.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_deb     <= 1'b0;
      r_debPrev <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_key;
      r_s2      <= r_s1;
      r_debPrev <= r_deb;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_rise = r_deb & ~r_debPrev;

endmodule

// File: rtl/key_input_conditioner.sv
// Turns the raw right/left/rotate buttons into clean one-cycle command pulses,
// with delayed auto-repeat on left and right while held.
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int CLOCK_FREQUENCY      = DEF_CLOCK_FREQUENCY,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = CLOCK_FREQUENCY / 4,
  parameter int REPEAT_PERIOD_CYCLES = CLOCK_FREQUENCY / 10
) (
  input  logic clk,
  input  logic iReset,
  input  logic iEn,
  input  logic iKeyRight,
  input  logic iKeyLeft,
  input  logic iKeyRotate,
  output logic oMoveRight,
  output logic oMoveLeft,
  output logic oRotate
);

  localparam int CW = $clog2(maxOf(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;

  logic [2:0] w_keys;
  logic [2:0] w_deb;
  logic [2:0] w_rise;
  logic [1:0] w_pulse;
  logic       w_conflict;
  logic       r_rotate;

  assign w_keys     = {iKeyRotate, iKeyLeft, iKeyRight};
  assign w_conflict = w_deb[0] & w_deb[1];

  for (genvar k = 0; k < 3; k++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .i_reset (iReset),
      .i_key   (w_keys[k]),
      .o_deb   (w_deb[k]),
      .o_rise  (w_rise[k])
    );
  end

  // Index 0 is right, 1 is left. Conflict masking only hides the pulse; the
  // FSM keeps counting so the schedule resumes unchanged once one key lets go.
  for (genvar k = 0; k < 2; k++) begin : g_repeat
    repeat_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;

    always_ff @(posedge clk) begin
      if (iReset) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!iEn) begin
          r_state <= w_deb[k] ? ST_LOCKED : ST_IDLE;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise[k]) begin
                r_pulse <= ~w_conflict;
                r_cnt   <= CW'(REPEAT_DELAY_CYCLES);
                r_state <= ST_DELAY;
              end
            end
            ST_DELAY, ST_REPEAT: begin
              if (!w_deb[k]) begin
                r_state <= ST_IDLE;
              end else if (r_cnt == CW'(1)) begin
                r_pulse <= ~w_conflict;
                r_cnt   <= CW'(REPEAT_PERIOD_CYCLES);
                r_state <= ST_REPEAT;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
            ST_LOCKED: begin
              if (!w_deb[k]) begin
                r_state <= ST_IDLE;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end

    assign w_pulse[k] = r_pulse;
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      r_rotate <= 1'b0;
    end else begin
      r_rotate <= iEn & w_rise[2];
    end
  end

  assign oMoveRight = w_pulse[0];
  assign oMoveLeft  = w_pulse[1];
  assign oRotate    = r_rotate;

endmodule
